pc_predict_unit: RTL and testbench

Next-generation fetch program counter. It is parametrised in width, reset vector and predictor depth. It adds stall, trap and redirect priority, plus a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so fetch can follow predicted-taken branches without waiting for execute.

---
 rtl/pc_predict_unit.sv | 115 +++++++++++
 tb/tb_pc_predict_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_predict_unit.sv
// Fetch PC generator with trap/redirect/stall priority and a
// direct-mapped BTB using 2-bit saturating direction counters.
module pc_predict_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               BTB_ENTRIES  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_target,
  input  logic             i_trap,
  input  logic [WIDTH-1:0] i_trap_vector,
  input  logic             i_upd_valid,
  input  logic [WIDTH-1:0] i_upd_pc,
  input  logic [WIDTH-1:0] i_upd_target,
  input  logic             i_upd_taken,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_pred_taken,
  output logic [WIDTH-1:0] o_pred_target
);

  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW  = WIDTH - IDX - 2;
  localparam logic [WIDTH-1:0] ALIGN = ~WIDTH'(3);

  logic [WIDTH-1:0] r_pc;
  logic             r_valid [BTB_ENTRIES];
  logic [TW-1:0]    r_tag   [BTB_ENTRIES];
  logic [WIDTH-1:0] r_tgt   [BTB_ENTRIES];
  logic [1:0]       r_ctr   [BTB_ENTRIES];

  logic [IDX-1:0]   w_idx;
  logic             w_hit;
  logic             w_pred;
  logic [WIDTH-1:0] w_pred_tgt;
  logic [WIDTH-1:0] w_next_pc;
  logic [IDX-1:0]   w_uidx;
  logic [TW-1:0]    w_utag;
  logic             w_uhit;
  logic [1:0]       w_uctr;
  logic [1:0]       w_ctr_nx;
  logic             w_unused;

  // Lookup on the registered PC
  assign w_idx      = r_pc[IDX+1:2];
  assign w_hit      = r_valid[w_idx] &&
                      (r_tag[w_idx] == r_pc[WIDTH-1:IDX+2]);
  assign w_pred     = w_hit && r_ctr[w_idx][1];
  assign w_pred_tgt = w_hit ? r_tgt[w_idx] : '0;

  always_comb begin
    w_next_pc = r_pc + WIDTH'(4);
    if (i_trap)
      w_next_pc = i_trap_vector & ALIGN;
    else if (i_redirect)
      w_next_pc = i_redirect_target & ALIGN;
    else if (i_stall)
      w_next_pc = r_pc;
    else if (w_pred)
      w_next_pc = w_pred_tgt;
  end

  assign w_uidx = i_upd_pc[IDX+1:2];
  assign w_utag = i_upd_pc[WIDTH-1:IDX+2];
  assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_uctr = r_ctr[w_uidx];
  assign w_unused = ^i_upd_pc[1:0];

  always_comb begin
    w_ctr_nx = w_uctr;
    if (i_upd_taken) begin
      if (w_uctr != 2'b11) w_ctr_nx = w_uctr + 2'b01;
    end else begin
      if (w_uctr != 2'b00) w_ctr_nx = w_uctr - 2'b01;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= RESET_VECTOR & ALIGN;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_tgt[i]   <= '0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (i_upd_valid) begin
      if (w_uhit) begin
        r_ctr[w_uidx] <= w_ctr_nx;
        if (i_upd_taken)
          r_tgt[w_uidx] <= i_upd_target & ALIGN;
      end else if (i_upd_taken) begin
        // Miss-and-taken always steals the slot
        r_valid[w_uidx] <= 1'b1;
        r_tag[w_uidx]   <= w_utag;
        r_tgt[w_uidx]   <= i_upd_target & ALIGN;
        r_ctr[w_uidx]   <= 2'b10;
      end
    end
  end

  assign o_pc          = r_pc;
  assign o_pred_taken  = w_pred;
  assign o_pred_target = w_pred_tgt;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed vector table, async reset sequence and random
// traffic checked against an abstract fetch/BTB model.
module tb_pc_predict_unit;

  localparam int N = 8;
  localparam int IDX = 3;
  localparam logic [31:0] RV = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect, trap;
  logic        upd_valid, upd_taken;
  logic [31:0] redirect_target, trap_vector;
  logic [31:0] upd_pc, upd_target;
  logic [31:0] pc, pred_target;
  logic        pred_taken;

  int n_vec = 0;
  int n_bad = 0;

  pc_predict_unit #(
    .WIDTH(32), .RESET_VECTOR(RV), .BTB_ENTRIES(N)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_stall(stall), .i_redirect(redirect),
    .i_redirect_target(redirect_target),
    .i_trap(trap), .i_trap_vector(trap_vector),
    .i_upd_valid(upd_valid), .i_upd_pc(upd_pc),
    .i_upd_target(upd_target), .i_upd_taken(upd_taken),
    .o_pc(pc), .o_pred_taken(pred_taken),
    .o_pred_target(pred_target)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays, counter as an integer 0..3
  logic [31:0] m_pc;
  bit          m_v   [N];
  logic [31:0] m_tag [N];
  logic [31:0] m_tgt [N];
  int          m_ctr [N];

  function automatic int ix(input logic [31:0] a);
    return int'((a / 4) % N);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_v[ix(a)] && (m_tag[ix(a)] == (a >> (IDX + 2)));
  endfunction

  function automatic bit m_pt();
    return m_hit(m_pc) && (m_ctr[ix(m_pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptg();
    return m_hit(m_pc) ? m_tgt[ix(m_pc)] : 32'h0;
  endfunction

  task automatic m_reset();
    m_pc = RV;
    for (int i = 0; i < N; i++) begin
      m_v[i] = 1'b0; m_tag[i] = '0;
      m_tgt[i] = '0; m_ctr[i] = 1;
    end
  endtask

  task automatic m_step();
    logic [31:0] nx;
    int k;
    if (trap)          nx = trap_vector & ~32'd3;
    else if (redirect) nx = redirect_target & ~32'd3;
    else if (stall)    nx = m_pc;
    else if (m_pt())   nx = m_ptg();
    else               nx = m_pc + 32'd4;
    if (upd_valid) begin
      k = ix(upd_pc);
      if (m_hit(upd_pc)) begin
        if (upd_taken) begin
          m_ctr[k] = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
          m_tgt[k] = upd_target & ~32'd3;
        end else begin
          m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_v[k] = 1'b1;
        m_tag[k] = upd_pc >> (IDX + 2);
        m_tgt[k] = upd_target & ~32'd3;
        m_ctr[k] = 2;
      end
    end
    m_pc = nx;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string tg);
    chk({tg, ".pc"}, pc, m_pc);
    chk({tg, ".pt"}, {31'b0, pred_taken}, {31'b0, m_pt()});
    chk({tg, ".ptg"}, pred_target, m_ptg());
  endtask

  task automatic idle_in();
    stall = 0; redirect = 0; trap = 0; upd_valid = 0;
    upd_taken = 0; redirect_target = 0; trap_vector = 0;
    upd_pc = 0; upd_target = 0;
  endtask

  // Called at a negedge with inputs already driven
  task automatic cyc(input string tg);
    @(posedge clk);
    m_step();
    @(negedge clk);
    chk_model(tg);
  endtask

  typedef struct {
    logic        st, rd;
    logic [31:0] rt;
    logic        tr;
    logic [31:0] tv;
    logic        uv;
    logic [31:0] up, ut;
    logic        tk;
    logic [31:0] epc;
    logic        ept;
    logic [31:0] etg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic st, rd, input logic [31:0] rt,
    input logic tr, input logic [31:0] tv,
    input logic uv, input logic [31:0] up, ut,
    input logic tk, input logic [31:0] epc,
    input logic ept, input logic [31:0] etg);
    vec_t v;
    v.st = st; v.rd = rd; v.rt = rt; v.tr = tr; v.tv = tv;
    v.uv = uv; v.up = up; v.ut = ut; v.tk = tk;
    v.epc = epc; v.ept = ept; v.etg = etg;
    return v;
  endfunction

  initial begin
    // st rd rt tr tv uv up ut tk | pc pt tgt
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h104,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h108,0,0));
    tbl.push_back(mk(0,1,32'hFFFF_FFFC,0,0,0,0,0,0,
                     32'hFFFF_FFFC,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 32'h0,0,0));
    tbl.push_back(mk(0,1,32'h20,0,0,1,32'h20,32'h80,1,
                     32'h20,1,32'h80));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h80,0,0));
    tbl.push_back(mk(0,1,32'h20,0,0,1,32'h20,0,0,
                     32'h20,0,32'h80));
    tbl.push_back(mk(1,0,0,0,0,1,32'h20,32'h80,1,
                     32'h20,1,32'h80));
    tbl.push_back(mk(1,0,0,0,0,1,32'h20,32'h87,1,
                     32'h20,1,32'h84));
    tbl.push_back(mk(1,0,0,0,0,1,32'h20,0,0, 32'h20,1,32'h84));
    tbl.push_back(mk(1,0,0,0,0,1,32'h20,0,0, 32'h20,0,32'h84));
    tbl.push_back(mk(1,0,0,0,0,1,32'h20,0,0, 32'h20,0,32'h84));
    tbl.push_back(mk(1,0,0,0,0,1,32'h20,0,0, 32'h20,0,32'h84));
    tbl.push_back(mk(1,0,0,0,0,1,32'h20,32'h84,1,
                     32'h20,0,32'h84));
    tbl.push_back(mk(1,1,32'h200,1,32'h400,0,0,0,0,
                     32'h400,0,0));
    tbl.push_back(mk(1,1,32'h200,0,0,0,0,0,0, 32'h200,0,0));
    tbl.push_back(mk(0,1,32'h203,0,0,0,0,0,0, 32'h200,0,0));
    tbl.push_back(mk(0,1,32'h20,0,0,1,32'h40,32'h300,1,
                     32'h20,0,0));
    tbl.push_back(mk(0,1,32'h40,0,0,0,0,0,0, 32'h40,1,32'h300));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h300,0,0));
    tbl.push_back(mk(0,0,0,1,32'h403,0,0,0,0, 32'h400,0,0));

    idle_in();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst.pc", pc, RV);
    chk("rst.pt", {31'b0, pred_taken}, 32'h0);
    chk("rst.ptg", pred_target, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_model("rel");

    foreach (tbl[i]) begin
      stall = tbl[i].st; redirect = tbl[i].rd;
      redirect_target = tbl[i].rt; trap = tbl[i].tr;
      trap_vector = tbl[i].tv; upd_valid = tbl[i].uv;
      upd_pc = tbl[i].up; upd_target = tbl[i].ut;
      upd_taken = tbl[i].tk;
      cyc($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.pc", i), pc, tbl[i].epc);
      chk($sformatf("tbl%0d.pt", i),
          {31'b0, pred_taken}, {31'b0, tbl[i].ept});
      chk($sformatf("tbl%0d.ptg", i), pred_target, tbl[i].etg);
    end

    for (int i = 0; i < 400; i++) begin
      trap = ($urandom % 16) == 0;
      redirect = ($urandom % 8) == 0;
      stall = ($urandom % 5) == 0;
      trap_vector = $urandom_range(0, 511);
      redirect_target = $urandom_range(0, 511);
      upd_valid = ($urandom % 2) == 0;
      upd_pc = (($urandom % 4) == 0) ? m_pc
                                     : $urandom_range(0, 511);
      upd_target = $urandom_range(0, 511);
      upd_taken = ($urandom % 3) != 0;
      cyc($sformatf("rnd%0d", i));
    end

    idle_in();
    redirect = 1; redirect_target = 32'h140;
    cyc("to140");
    chk("at140", pc, 32'h140);
    idle_in();
    upd_valid = 1; upd_pc = 32'h100;
    upd_target = 32'h500; upd_taken = 1;
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst.pc", pc, 32'h100);
    chk("arst.pt", {31'b0, pred_taken}, 32'h0);
    @(negedge clk);
    chk_model("arst.hold");
    idle_in();
    rst_n = 1'b1;
    cyc("r1");
    chk("r1.pc", pc, 32'h104);
    cyc("r2");
    chk("r2.pc", pc, 32'h108);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
